// File: rtl/store_lane_pack_unit_pkg.sv
// Shared encodings for the store lane packing path: access sizes and byte-enable patterns.
package store_lane_pack_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_B0  = 4'b0001;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store narrowing: replicates data across byte lanes, builds byte enables
// and flags misaligned or reserved-size accesses.
module store_lane_pack
  import store_lane_pack_unit_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic              misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    wdata      = data;
    be         = '0;
    misaligned = 1'b0;
    case (size_e'(size))
      SIZE_B: begin
        wdata = {4{data[7:0]}};
        be    = BE_B0 << addr_lo;
      end
      SIZE_H: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? BE_HI : BE_LO;
        misaligned = addr_lo[0];
      end
      SIZE_W: begin
        be         = BE_ALL;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_lane_pack_unit.sv
// Store path between EX/MEM and the data-memory write port: packs lanes, traps misaligned
// stores and buffers up to two writes behind a valid/ready handshake.
module store_lane_pack_unit
  import store_lane_pack_unit_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  output logic              ades,
  output logic [AW-1:0]     ades_addr,
  output logic              busy
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [DATA_W-1:0] pk_wdata;
  logic [3:0]        pk_be;
  logic              pk_mis;

  store_lane_pack u_pack (
    .addr_lo    (req_addr[1:0]),
    .size       (req_size),
    .data       (req_data),
    .wdata      (pk_wdata),
    .be         (pk_be),
    .misaligned (pk_mis)
  );

  logic [1:0]        count, count_next;
  logic              wr_ptr, rd_ptr;
  logic              ready_q;
  logic              accept, push, pop;
  logic [AW-3:0]     buf_addr  [DEPTH];
  logic [DATA_W-1:0] buf_wdata [DEPTH];
  logic [3:0]        buf_be    [DEPTH];

  assign req_ready = ready_q;
  assign accept    = req_valid && req_ready;
  // Misaligned stores complete the handshake but never reach the buffer.
  assign push      = accept && !pk_mis;
  assign mem_valid = (count != 2'd0);
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      ades      <= 1'b0;
      ades_addr <= '0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next < FULL);
      busy    <= (count_next != 2'd0);
      ades    <= accept && pk_mis;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (accept && pk_mis) ades_addr <= req_addr;
    end
  end

  // NOTE: buffer storage has no reset; the outputs below are qualified by occupancy,
  // so stale contents never leave the unit.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr]  <= req_addr[AW-1:2];
      buf_wdata[wr_ptr] <= pk_wdata;
      buf_be[wr_ptr]    <= pk_be;
    end
  end

  assign mem_addr  = mem_valid ? {buf_addr[rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_valid ? buf_wdata[rd_ptr] : '0;
  assign mem_be    = mem_valid ? buf_be[rd_ptr] : '0;

endmodule
